// File: rtl/decode_arbiter_pkg.sv
// Shared types and constants for the decode-to-issue arbiter.
// The arbiter and its skid buffer both import this package.
package decode_arbiter_pkg;

  localparam int DEC_W   = 64;
  localparam int MAX_UOP = 8;
  localparam int CNT_W   = 4;

  // The field widths add up to DEC_W (5+5+5+1+32+4+12 = 64).
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        invalid;
    logic [31:0] imm_data;
    logic [3:0]  unit;
    logic [11:0] command;
  } DecOp_t;

  typedef enum logic {
    IDLE = 1'b0,
    CPLX = 1'b1
  } ArbState_t;

endpackage

// File: rtl/decode_arbiter_if.sv
// Decoder, scheduler and status signals of the decode arbiter.
// The slave modport is the arbiter side; the master modport is the environment side.
interface decode_arbiter_if #(
  parameter int DEC_W = decode_arbiter_pkg::DEC_W
);

  logic             s_e_;
  logic [DEC_W-1:0] s_op;
  logic             s_stall;
  logic             c_e_;
  logic             c_last;
  logic [DEC_W-1:0] c_op;
  logic             c_stall;
  logic             is_full;
  logic             dec_e_;
  logic [DEC_W-1:0] dec_op;
  logic             cplx_busy;
  logic             uop_ovf;

  modport slave (
    input  s_e_, s_op, c_e_, c_last, c_op, is_full,
    output s_stall, c_stall, dec_e_, dec_op, cplx_busy, uop_ovf
  );

  modport master (
    output s_e_, s_op, c_e_, c_last, c_op, is_full,
    input  s_stall, c_stall, dec_e_, dec_op, cplx_busy, uop_ovf
  );

endinterface

// File: rtl/decode_arbiter_dec_skid_buf.sv
// Two-entry registered FIFO between the arbiter and the scheduler port.
// Entry 0 is always the head; the head reads as zero while the FIFO is empty.
module dec_skid_buf #(
  parameter int W = decode_arbiter_pkg::DEC_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);
  import decode_arbiter_pkg::*;

  logic [W-1:0] entry0;
  logic [W-1:0] entry1;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = (count != 2'd0) ? entry0 : '0;

  // A simultaneous push and pop keeps the count and shifts the queue forward.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= push_data;
          else               entry1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            entry0 <= push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/decode_arbiter.sv
// Arbitrates the single decode-to-issue port between the simple and complex decoders,
// holding the port for the complex decoder until its micro-op sequence ends.
module decode_arbiter #(
  parameter int DEC_W   = decode_arbiter_pkg::DEC_W,
  parameter int MAX_UOP = decode_arbiter_pkg::MAX_UOP,
  parameter int CNT_W   = decode_arbiter_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  decode_arbiter_if.slave  bus
);
  import decode_arbiter_pkg::*;

  ArbState_t        state;
  logic [CNT_W-1:0] uop_cnt;
  logic             busy;
  logic             ovf;

  logic [1:0]       count;
  logic [DEC_W-1:0] head;
  logic [DEC_W-1:0] push_op;
  logic             pop;
  logic             space;
  logic             grant_s;
  logic             grant_c;
  logic             acc_s;
  logic             acc_c;
  logic             push;

  // Flush blocks every transfer in its own cycle, so it gates pop and both stalls.
  assign pop     = (count != 2'd0) && !bus.is_full && !flush;
  assign space   = (count != 2'd2) || pop;
  assign grant_c = (state == CPLX) || !bus.c_e_;
  assign grant_s = (state == IDLE) && bus.c_e_ && !bus.s_e_;

  assign bus.s_stall = flush || !(grant_s && space);
  assign bus.c_stall = flush || !(grant_c && space);

  assign acc_c   = !bus.c_e_ && !bus.c_stall;
  assign acc_s   = !bus.s_e_ && !bus.s_stall;
  assign push    = acc_c || acc_s;
  assign push_op = acc_c ? bus.c_op : bus.s_op;

  assign bus.dec_e_    = !pop;
  assign bus.dec_op    = head;
  assign bus.cplx_busy = busy;
  assign bus.uop_ovf   = ovf;

  dec_skid_buf #(.W(DEC_W)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (push_op),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  // A runaway sequence is cut off at MAX_UOP micro-ops; its last op is still pushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      uop_cnt <= '0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
    end else if (flush) begin
      state   <= IDLE;
      uop_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_c && !bus.c_last) begin
            state   <= CPLX;
            uop_cnt <= CNT_W'(1);
            busy    <= 1'b1;
          end
        end
        CPLX: begin
          if (acc_c) begin
            if (bus.c_last) begin
              state   <= IDLE;
              uop_cnt <= '0;
              busy    <= 1'b0;
            end else if (uop_cnt == CNT_W'(MAX_UOP - 1)) begin
              ovf     <= 1'b1;
              state   <= IDLE;
              uop_cnt <= '0;
              busy    <= 1'b0;
            end else begin
              uop_cnt <= uop_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_arbiter.sv
// Directed bench for decode_arbiter: a one-cycle-per-row vector table followed by
// hand-written overflow, flush and reset sequences.
module tb_decode_arbiter;

  logic clk;
  logic reset;
  logic flush;

  int checkCount = 0;
  int passCount  = 0;

  decode_arbiter_if #(.DEC_W(64)) bus ();

  decode_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        se;
    logic [63:0] so;
    logic        ce;
    logic        cl;
    logic [63:0] co;
    logic        full;
    logic        expSs;
    logic        expCs;
    logic        expDe;
    logic [63:0] expDop;
    logic        expBusy;
    logic        expOvf;
  } Vec_t;

  Vec_t vecs[18];

  function automatic Vec_t mk(input logic fl, input logic se, input logic [63:0] so,
                              input logic ce, input logic cl, input logic [63:0] co,
                              input logic full, input logic ss, input logic cs,
                              input logic de, input logic [63:0] dop,
                              input logic busy, input logic ovf);
    Vec_t v;
    v.fl = fl; v.se = se; v.so = so; v.ce = ce; v.cl = cl; v.co = co; v.full = full;
    v.expSs = ss; v.expCs = cs; v.expDe = de; v.expDop = dop;
    v.expBusy = busy; v.expOvf = ovf;
    return v;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
  task automatic driveCycle(input logic rst, input logic fl, input logic se,
                            input logic [63:0] so, input logic ce, input logic cl,
                            input logic [63:0] co, input logic full);
    @(posedge clk);
    #1;
    reset       = rst;
    flush       = fl;
    bus.s_e_    = se;
    bus.s_op    = so;
    bus.c_e_    = ce;
    bus.c_last  = cl;
    bus.c_op    = co;
    bus.is_full = full;
    #4;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input int idx, input Vec_t v);
    driveCycle(1'b0, v.fl, v.se, v.so, v.ce, v.cl, v.co, v.full);
    checkOutput($sformatf("vec%0d s_stall", idx),   64'(bus.s_stall),   64'(v.expSs));
    checkOutput($sformatf("vec%0d c_stall", idx),   64'(bus.c_stall),   64'(v.expCs));
    checkOutput($sformatf("vec%0d dec_e_", idx),    64'(bus.dec_e_),    64'(v.expDe));
    checkOutput($sformatf("vec%0d dec_op", idx),    bus.dec_op,         v.expDop);
    checkOutput($sformatf("vec%0d cplx_busy", idx), 64'(bus.cplx_busy), 64'(v.expBusy));
    checkOutput($sformatf("vec%0d uop_ovf", idx),   64'(bus.uop_ovf),   64'(v.expOvf));
  endtask

  initial begin
    //                fl se so     ce cl co     full  ss cs de dop    busy ovf
    vecs[0]  = mk(0, 0, 'h11, 1, 0, 0,     0,   0, 1, 1, 0,     0, 0);
    vecs[1]  = mk(0, 0, 'h12, 1, 0, 0,     0,   0, 1, 0, 'h11,  0, 0);
    vecs[2]  = mk(0, 1, 0,    1, 0, 0,     0,   1, 1, 0, 'h12,  0, 0);
    vecs[3]  = mk(0, 0, 'h33, 0, 0, 'h21,  0,   1, 0, 1, 0,     0, 0);
    vecs[4]  = mk(0, 0, 'h33, 0, 1, 'h22,  0,   1, 0, 0, 'h21,  1, 0);
    vecs[5]  = mk(0, 0, 'h33, 1, 0, 0,     0,   0, 1, 0, 'h22,  0, 0);
    vecs[6]  = mk(0, 1, 0,    1, 0, 0,     0,   1, 1, 0, 'h33,  0, 0);
    vecs[7]  = mk(0, 0, 'h01, 1, 0, 0,     1,   0, 1, 1, 0,     0, 0);
    vecs[8]  = mk(0, 0, 'h02, 1, 0, 0,     1,   0, 1, 1, 'h01,  0, 0);
    vecs[9]  = mk(0, 0, 'h03, 1, 0, 0,     1,   1, 1, 1, 'h01,  0, 0);
    vecs[10] = mk(0, 0, 'h03, 1, 0, 0,     0,   0, 1, 0, 'h01,  0, 0);
    vecs[11] = mk(0, 1, 0,    1, 0, 0,     0,   1, 1, 0, 'h02,  0, 0);
    vecs[12] = mk(0, 1, 0,    1, 0, 0,     0,   1, 1, 0, 'h03,  0, 0);
    vecs[13] = mk(0, 1, 0,    1, 0, 0,     0,   1, 1, 1, 0,     0, 0);
    vecs[14] = mk(0, 1, 0,    0, 1, 'h44,  0,   1, 0, 1, 0,     0, 0);
    vecs[15] = mk(0, 0, 'h55, 1, 1, 0,     0,   0, 1, 0, 'h44,  0, 0);
    vecs[16] = mk(0, 1, 0,    1, 0, 0,     0,   1, 1, 0, 'h55,  0, 0);
    vecs[17] = mk(0, 1, 0,    1, 0, 0,     0,   1, 1, 1, 0,     0, 0);

    reset = 1'b1; flush = 1'b0;
    bus.s_e_ = 1'b1; bus.s_op = '0; bus.c_e_ = 1'b1; bus.c_last = 1'b0;
    bus.c_op = '0; bus.is_full = 1'b0;

    driveCycle(1, 0, 1, 0, 1, 0, 0, 0);
    driveCycle(1, 0, 1, 0, 1, 0, 0, 0);
    driveCycle(0, 0, 1, 0, 1, 0, 0, 0);
    checkOutput("reset s_stall",   64'(bus.s_stall),   64'(1));
    checkOutput("reset c_stall",   64'(bus.c_stall),   64'(1));
    checkOutput("reset dec_e_",    64'(bus.dec_e_),    64'(1));
    checkOutput("reset dec_op",    bus.dec_op,         64'(0));
    checkOutput("reset cplx_busy", 64'(bus.cplx_busy), 64'(0));
    checkOutput("reset uop_ovf",   64'(bus.uop_ovf),   64'(0));

    for (int i = 0; i < 18; i++) applyStimulus(i, vecs[i]);

    // Eight micro-ops without c_last: the eighth trips the overflow flag.
    for (int i = 0; i < 8; i++) begin
      driveCycle(0, 0, 1, 0, 0, 0, 64'h80 + 64'(i), 0);
      checkOutput($sformatf("ovf seq%0d c_stall", i), 64'(bus.c_stall), 64'(0));
      checkOutput($sformatf("ovf seq%0d uop_ovf", i), 64'(bus.uop_ovf), 64'(0));
      if (i > 0) begin
        checkOutput($sformatf("ovf seq%0d dec_op", i), bus.dec_op, 64'h80 + 64'(i - 1));
        checkOutput($sformatf("ovf seq%0d cplx_busy", i), 64'(bus.cplx_busy), 64'(1));
      end
    end
    driveCycle(0, 0, 0, 64'h90, 1, 0, 0, 0);
    checkOutput("ovf set uop_ovf",   64'(bus.uop_ovf),   64'(1));
    checkOutput("ovf set cplx_busy", 64'(bus.cplx_busy), 64'(0));
    checkOutput("ovf idle s_stall",  64'(bus.s_stall),   64'(0));
    checkOutput("ovf last dec_op",   bus.dec_op,         64'h87);
    driveCycle(0, 0, 1, 0, 1, 0, 0, 0);
    checkOutput("ovf simple dec_op", bus.dec_op, 64'h90);
    driveCycle(0, 1, 1, 0, 1, 0, 0, 0);
    driveCycle(0, 0, 1, 0, 1, 0, 0, 0);
    checkOutput("ovf after flush", 64'(bus.uop_ovf), 64'(1));

    // Flush in the middle of a complex sequence with both entries occupied.
    driveCycle(0, 0, 0, 64'h77, 0, 0, 64'h61, 1);
    checkOutput("fl c1 c_stall", 64'(bus.c_stall), 64'(0));
    driveCycle(0, 0, 0, 64'h77, 0, 0, 64'h62, 1);
    checkOutput("fl c2 c_stall",   64'(bus.c_stall),   64'(0));
    checkOutput("fl c2 cplx_busy", 64'(bus.cplx_busy), 64'(1));
    checkOutput("fl c2 dec_op",    bus.dec_op,         64'h61);
    driveCycle(0, 1, 0, 64'h77, 0, 0, 64'h63, 0);
    checkOutput("fl c3 dec_e_",  64'(bus.dec_e_),  64'(1));
    checkOutput("fl c3 s_stall", 64'(bus.s_stall), 64'(1));
    checkOutput("fl c3 c_stall", 64'(bus.c_stall), 64'(1));
    driveCycle(0, 0, 0, 64'h05, 1, 0, 0, 0);
    checkOutput("fl c4 cplx_busy", 64'(bus.cplx_busy), 64'(0));
    checkOutput("fl c4 dec_e_",    64'(bus.dec_e_),    64'(1));
    checkOutput("fl c4 s_stall",   64'(bus.s_stall),   64'(0));
    driveCycle(0, 0, 1, 0, 1, 0, 0, 0);
    checkOutput("fl c5 dec_e_", 64'(bus.dec_e_), 64'(0));
    checkOutput("fl c5 dec_op", bus.dec_op,      64'h05);

    // Reset while mid-sequence, buffer full and the scheduler blocked.
    driveCycle(0, 0, 1, 0, 0, 0, 64'hA1, 1);
    driveCycle(0, 0, 1, 0, 0, 0, 64'hA2, 1);
    checkOutput("rst pre cplx_busy", 64'(bus.cplx_busy), 64'(1));
    driveCycle(0, 0, 1, 0, 0, 0, 64'hA3, 1);
    checkOutput("rst pre c_stall", 64'(bus.c_stall), 64'(1));
    checkOutput("rst pre uop_ovf", 64'(bus.uop_ovf), 64'(1));
    driveCycle(1, 0, 1, 0, 1, 0, 0, 1);
    driveCycle(0, 0, 1, 0, 1, 0, 0, 0);
    checkOutput("rst post dec_e_",    64'(bus.dec_e_),    64'(1));
    checkOutput("rst post dec_op",    bus.dec_op,         64'(0));
    checkOutput("rst post uop_ovf",   64'(bus.uop_ovf),   64'(0));
    checkOutput("rst post cplx_busy", 64'(bus.cplx_busy), 64'(0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
